// File: rtl/imm_extend_pipe_if.sv
// Decode-to-extender handshake bundle: input side (valid/ready, mode, raw
// immediate) and output side (valid/ready, extended operand).
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [2:0]       mode_i;
  logic [IN_W-1:0]  data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [OUT_W-1:0] data_o;

  modport master (
    output in_valid_i, mode_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o
  );

  modport slave (
    input  in_valid_i, mode_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (sign/zero/upper/branch-offset) with a one-entry
// skid buffer. Optional EXT_ILLEGAL_CHK_EN adds a sticky err_o for modes 4-7.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
`ifdef EXT_ILLEGAL_CHK_EN
  output logic err_o,
`endif
  imm_extend_pipe_if.slave bus
);

  localparam logic [2:0] MODE_SIGN    = 3'd0;
  localparam logic [2:0] MODE_ZERO    = 3'd1;
  localparam logic [2:0] MODE_UPPER   = 3'd2;
  localparam logic [2:0] MODE_BRSHIFT = 3'd3;

  generate
    if (IN_W < 2 || OUT_W < IN_W + 2) begin : g_bad_params
      $error("imm_extend_pipe: need IN_W >= 2 and OUT_W >= IN_W+2");
    end
  endgenerate

  logic             r_main_valid;
  logic [OUT_W-1:0] r_main_data;
  logic             r_skid_valid;
  logic [OUT_W-1:0] r_skid_data;

  logic             w_accept;
  logic             w_consume;
  logic [OUT_W-1:0] w_sign;
  logic [OUT_W-1:0] w_ext;

  // Ready depends only on skid occupancy, so no combinational path from out_ready.
  assign w_accept  = bus.in_valid_i && !r_skid_valid;
  assign w_consume = r_main_valid && bus.out_ready_i;
  assign w_sign    = {{(OUT_W-IN_W){bus.data_i[IN_W-1]}}, bus.data_i};

  always_comb begin
    w_ext = w_sign;
    case (bus.mode_i)
      MODE_SIGN:    w_ext = w_sign;
      MODE_ZERO:    w_ext = {{(OUT_W-IN_W){1'b0}}, bus.data_i};
      MODE_UPPER:   w_ext = {bus.data_i, {(OUT_W-IN_W){1'b0}}};
      MODE_BRSHIFT: w_ext = {w_sign[OUT_W-3:0], 2'b00};
`ifdef EXT_ILLEGAL_CHK_EN
      default:      w_ext = '0;
`else
      default:      w_ext = w_sign;
`endif
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (flush_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_accept) begin
      if (!r_main_valid || w_consume) begin
        r_main_valid <= 1'b1;
        r_main_data  <= w_ext;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_ext;
      end
    end else if (w_consume) begin
      if (r_skid_valid) begin
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready_o  = !r_skid_valid;
  assign bus.out_valid_o = r_main_valid;
  assign bus.data_o      = r_main_data;

`ifdef EXT_ILLEGAL_CHK_EN
  logic r_err;

  // Sticky until reset; flush deliberately leaves it set.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err <= 1'b0;
    end else if (w_accept && bus.mode_i[2]) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed-vector bench for imm_extend_pipe; expected values hand-computed.
// Also exercises err_o when built with EXT_ILLEGAL_CHK_EN.
module tb_imm_extend_pipe;

  logic clk;
  logic rst_n;
  logic flush;
`ifdef EXT_ILLEGAL_CHK_EN
  logic err;
`endif

  int n_vec;
  int n_err;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .flush_i (flush),
`ifdef EXT_ILLEGAL_CHK_EN
    .err_o   (err),
`endif
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] d);
    bus.in_valid_i = v;
    bus.mode_i     = m;
    bus.data_i     = d;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready_i = 1'b1;
    drive(1'b0, 3'd0, 16'h0000);
    step();
    step();
    chk("rst_out_valid", {31'b0, bus.out_valid_o}, 32'd0);
    chk("rst_data", bus.data_o, 32'h0);
    chk("rst_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
`ifdef EXT_ILLEGAL_CHK_EN
    chk("rst_err", {31'b0, err}, 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Single SIGN transaction, then back-to-back modes
    drive(1'b1, 3'd0, 16'h8001);
    step();
    chk("sign_valid", {31'b0, bus.out_valid_o}, 32'd1);
    chk("sign_data", bus.data_o, 32'hFFFF8001);
    chk("sign_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
    drive(1'b1, 3'd1, 16'h8001);
    step();
    chk("zero_data", bus.data_o, 32'h00008001);
    drive(1'b1, 3'd2, 16'h1234);
    step();
    chk("upper_data", bus.data_o, 32'h12340000);
    drive(1'b1, 3'd3, 16'hFFFF);
    step();
    chk("brshift_data", bus.data_o, 32'hFFFFFFFC);
    drive(1'b1, 3'd3, 16'h4001);
    step();
    chk("brshift_pos", bus.data_o, 32'h00010004);
    drive(1'b0, 3'd0, 16'h0000);
    step();
    chk("drain_valid", {31'b0, bus.out_valid_o}, 32'd0);

    // Backpressure fills MAIN then SKID
    bus.out_ready_i = 1'b0;
    drive(1'b1, 3'd0, 16'h0001);
    step();
    chk("bp_a_valid", {31'b0, bus.out_valid_o}, 32'd1);
    drive(1'b1, 3'd0, 16'h0002);
    step();
    chk("bp_in_ready", {31'b0, bus.in_ready_o}, 32'd0);
    chk("bp_hold_a", bus.data_o, 32'h1);
    drive(1'b1, 3'd0, 16'h0BAD);
    step();
    chk("bp_hold_a2", bus.data_o, 32'h1);
    drive(1'b0, 3'd0, 16'h0000);
    bus.out_ready_i = 1'b1;
    chk("bp_deliver_a", bus.data_o, 32'h1);
    step();
    chk("bp_deliver_b", bus.data_o, 32'h2);
    chk("bp_b_valid", {31'b0, bus.out_valid_o}, 32'd1);
    chk("bp_ready_back", {31'b0, bus.in_ready_o}, 32'd1);
    step();
    chk("bp_empty", {31'b0, bus.out_valid_o}, 32'd0);

    // Flush with MAIN and SKID full, input presented
    bus.out_ready_i = 1'b0;
    drive(1'b1, 3'd0, 16'h0011);
    step();
    drive(1'b1, 3'd0, 16'h0022);
    step();
    drive(1'b1, 3'd0, 16'h7FFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 3'd0, 16'h0000);
    chk("flush_valid", {31'b0, bus.out_valid_o}, 32'd0);
    chk("flush_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
    chk("flush_data_kept", bus.data_o, 32'h11);
    bus.out_ready_i = 1'b1;
    step();
    chk("flush_no_7fff", bus.data_o, 32'h11);

    // Flush while the incoming handshake completes: input discarded
    bus.out_ready_i = 1'b0;
    drive(1'b1, 3'd1, 16'h0033);
    step();
    drive(1'b1, 3'd0, 16'h7FFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 3'd0, 16'h0000);
    chk("flush2_valid", {31'b0, bus.out_valid_o}, 32'd0);
    chk("flush2_data", bus.data_o, 32'h33);
    step();
    chk("flush2_still_empty", {31'b0, bus.out_valid_o}, 32'd0);

    // Asynchronous reset mid-cycle
    drive(1'b1, 3'd0, 16'h0044);
    step();
    drive(1'b0, 3'd0, 16'h0000);
    chk("pre_arst_valid", {31'b0, bus.out_valid_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, bus.out_valid_o}, 32'd0);
    chk("arst_data", bus.data_o, 32'h0);
    chk("arst_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
    step();
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    step();

    // Reserved mode
    drive(1'b1, 3'd5, 16'hABCD);
    step();
    drive(1'b0, 3'd0, 16'h0000);
`ifdef EXT_ILLEGAL_CHK_EN
    chk("rsv_data_zero", bus.data_o, 32'h0);
    chk("rsv_valid", {31'b0, bus.out_valid_o}, 32'd1);
    chk("rsv_err_set", {31'b0, err}, 32'd1);
    drive(1'b1, 3'd0, 16'h0005);
    step();
    drive(1'b0, 3'd0, 16'h0000);
    chk("err_sticky_data", bus.data_o, 32'h5);
    chk("err_sticky", {31'b0, err}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("err_survives_flush", {31'b0, err}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("err_cleared", {31'b0, err}, 32'd0);
    rst_n = 1'b1;
`else
    chk("rsv_as_sign", bus.data_o, 32'hFFFFABCD);
    drive(1'b1, 3'd7, 16'h1234);
    step();
    drive(1'b0, 3'd0, 16'h0000);
    chk("rsv7_as_sign", bus.data_o, 32'h00001234);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
